// File: rtl/reorder_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reorder_buffer_pkg
// Purpose  : Shared definitions for the reorder buffer: geometry defaults,
//            exception cause codes and the per-entry storage record.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package reorder_buffer_pkg;

    localparam int ROB_ENTRIES = 10;
    localparam int ROB_IDX_W   = 4;

    // Exception cause codes carried in the 3-bit vector; zero means no fault.
    localparam logic [2:0] EXC_NONE        = 3'd0;
    localparam logic [2:0] EXC_ILLEGAL     = 3'd1;
    localparam logic [2:0] EXC_LOAD_MISS   = 3'd2;
    localparam logic [2:0] EXC_STORE_MISS  = 3'd3;
    localparam logic [2:0] EXC_MISALIGNED  = 3'd4;

    typedef struct packed {
        logic        valid;
        logic        complete;
        logic        wb;
        logic        is_store;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [31:0] data;
        logic [2:0]  exc_vector;
        logic [31:0] addr_miss;
    } rob_entry_t;

endpackage : reorder_buffer_pkg
`default_nettype wire

// File: rtl/reorder_buffer.sv
`default_nettype none
// ============================================================================
// Module   : reorder_buffer
// Purpose  : Circular in-order commit buffer. Decode allocates at the tail,
//            execution stages complete entries by index, and the head entry
//            retires in program order once complete.
// Ports    :
//   clk, reset                       clock / async active-high reset
//   in_allocate*                     new entry request and its attributes
//   out_allocate_idx                 tail index handed to decode
//   out_full / out_empty             occupancy status (from registered count)
//   in_complete*                     completion of an entry with result/fault
//   in_flush                         redirect: discard every entry
//   out_commit_*                     register-file write / store drain pulse
//   out_exception*, out_addr_miss    precise exception report at retirement
// Revision : 1.0  initial release
// ============================================================================
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int ENTRIES = ROB_ENTRIES,
    parameter int IDX_W   = ROB_IDX_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_allocate,
    input  logic [4:0]        in_allocate_rd,
    input  logic              in_allocate_wb,
    input  logic              in_allocate_is_store,
    input  logic [31:0]       in_allocate_pc,
    output logic [IDX_W-1:0]  out_allocate_idx,
    output logic              out_full,
    output logic              out_empty,
    input  logic              in_complete,
    input  logic [IDX_W-1:0]  in_complete_idx,
    input  logic [31:0]       in_complete_data,
    input  logic [2:0]        in_complete_exception_vector,
    input  logic [31:0]       in_complete_addr_miss,
    input  logic              in_flush,
    output logic              out_commit_write_enable,
    output logic [4:0]        out_commit_reg,
    output logic [31:0]       out_commit_data,
    output logic              out_commit_store,
    output logic [IDX_W-1:0]  out_commit_idx,
    output logic              out_exception,
    output logic [2:0]        out_exception_vector,
    output logic [31:0]       out_exception_pc,
    output logic [31:0]       out_addr_miss
);

    localparam int               c_CNT_W    = $clog2(ENTRIES + 1);
    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(ENTRIES - 1);
    localparam logic [c_CNT_W-1:0] c_FULL_CNT = c_CNT_W'(ENTRIES);

    rob_entry_t           entries_q [ENTRIES];
    rob_entry_t           entries_d [ENTRIES];
    logic [IDX_W-1:0]     head_q, head_d;
    logic [IDX_W-1:0]     tail_q, tail_d;
    logic [c_CNT_W-1:0]   count_q, count_d;

    logic                 commit_we_q, commit_we_d;
    logic [4:0]           commit_reg_q, commit_reg_d;
    logic [31:0]          commit_data_q, commit_data_d;
    logic                 commit_store_q, commit_store_d;
    logic [IDX_W-1:0]     commit_idx_q, commit_idx_d;
    logic                 exc_q, exc_d;
    logic [2:0]           exc_vec_q, exc_vec_d;
    logic [31:0]          exc_pc_q, exc_pc_d;
    logic [31:0]          addr_miss_q, addr_miss_d;

    rob_entry_t           w_head;
    logic                 w_full;
    logic                 w_alloc;
    logic                 w_retire;
    logic                 w_exc_retire;
    logic                 w_cidx_ok;

    // Circular increment: the pointer never visits ENTRIES..2**IDX_W-1.
    function automatic logic [IDX_W-1:0] ptr_inc(input logic [IDX_W-1:0] p);
        return (p == c_LAST_IDX) ? '0 : p + IDX_W'(1);
    endfunction

    assign w_full           = (count_q == c_FULL_CNT);
    assign out_full         = w_full;
    assign out_empty        = (count_q == '0);
    assign out_allocate_idx = tail_q;

    assign w_head       = entries_q[head_q];
    assign w_alloc      = in_allocate && !w_full;
    assign w_retire     = w_head.valid && w_head.complete;
    assign w_exc_retire = w_retire && (w_head.exc_vector != EXC_NONE);
    // Completion indices beyond the last slot can only be garbage; drop them.
    assign w_cidx_ok    = (in_complete_idx <= c_LAST_IDX);

    always_comb begin
        entries_d      = entries_q;
        head_d         = head_q;
        tail_d         = tail_q;
        count_d        = count_q;
        commit_we_d    = 1'b0;
        commit_reg_d   = '0;
        commit_data_d  = '0;
        commit_store_d = 1'b0;
        commit_idx_d   = '0;
        exc_d          = 1'b0;
        exc_vec_d      = '0;
        exc_pc_d       = '0;
        addr_miss_d    = '0;

        // A faulting head is still reported even under an external flush;
        // either way the whole buffer is wiped at this edge.
        if (w_exc_retire) begin
            exc_d        = 1'b1;
            exc_vec_d    = w_head.exc_vector;
            exc_pc_d     = w_head.pc;
            addr_miss_d  = w_head.addr_miss;
            commit_idx_d = head_q;
        end

        if (w_exc_retire || in_flush) begin
            for (int i = 0; i < ENTRIES; i++) begin
                entries_d[i].valid = 1'b0;
            end
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            // Only a live entry may be completed; the allocate slot is never
            // live, so allocate and complete cannot collide.
            if (in_complete && w_cidx_ok && entries_q[in_complete_idx].valid) begin
                entries_d[in_complete_idx].complete   = 1'b1;
                entries_d[in_complete_idx].data       = in_complete_data;
                entries_d[in_complete_idx].exc_vector = in_complete_exception_vector;
                entries_d[in_complete_idx].addr_miss  = in_complete_addr_miss;
            end

            if (w_retire) begin
                entries_d[head_q].valid = 1'b0;
                head_d                  = ptr_inc(head_q);
                commit_idx_d            = head_q;
                if (w_head.wb && (w_head.rd != 5'd0)) begin
                    commit_we_d   = 1'b1;
                    commit_reg_d  = w_head.rd;
                    commit_data_d = w_head.data;
                end
                commit_store_d = w_head.is_store;
            end

            if (w_alloc) begin
                entries_d[tail_q].valid      = 1'b1;
                entries_d[tail_q].complete   = 1'b0;
                entries_d[tail_q].wb         = in_allocate_wb;
                entries_d[tail_q].is_store   = in_allocate_is_store;
                entries_d[tail_q].rd         = in_allocate_rd;
                entries_d[tail_q].pc         = in_allocate_pc;
                entries_d[tail_q].data       = '0;
                entries_d[tail_q].exc_vector = EXC_NONE;
                entries_d[tail_q].addr_miss  = '0;
                tail_d                       = ptr_inc(tail_q);
            end

            count_d = count_q + c_CNT_W'(w_alloc) - c_CNT_W'(w_retire);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                entries_q[i] <= '0;
            end
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            commit_we_q    <= 1'b0;
            commit_reg_q   <= '0;
            commit_data_q  <= '0;
            commit_store_q <= 1'b0;
            commit_idx_q   <= '0;
            exc_q          <= 1'b0;
            exc_vec_q      <= '0;
            exc_pc_q       <= '0;
            addr_miss_q    <= '0;
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                entries_q[i] <= entries_d[i];
            end
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            commit_we_q    <= commit_we_d;
            commit_reg_q   <= commit_reg_d;
            commit_data_q  <= commit_data_d;
            commit_store_q <= commit_store_d;
            commit_idx_q   <= commit_idx_d;
            exc_q          <= exc_d;
            exc_vec_q      <= exc_vec_d;
            exc_pc_q       <= exc_pc_d;
            addr_miss_q    <= addr_miss_d;
        end
    end

    assign out_commit_write_enable = commit_we_q;
    assign out_commit_reg          = commit_reg_q;
    assign out_commit_data         = commit_data_q;
    assign out_commit_store        = commit_store_q;
    assign out_commit_idx          = commit_idx_q;
    assign out_exception           = exc_q;
    assign out_exception_vector    = exc_vec_q;
    assign out_exception_pc        = exc_pc_q;
    assign out_addr_miss           = addr_miss_q;

endmodule : reorder_buffer
`default_nettype wire

// File: tb/tb_reorder_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_reorder_buffer
// Purpose  : Self-checking bench for reorder_buffer. A program-order queue
//            model predicts status and retirement outputs for directed
//            scenarios followed by randomized traffic.
// Revision : 1.0  initial release
// ============================================================================
module tb_reorder_buffer;

    localparam int N = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_allocate;
    logic [4:0]  in_allocate_rd;
    logic        in_allocate_wb;
    logic        in_allocate_is_store;
    logic [31:0] in_allocate_pc;
    logic [3:0]  out_allocate_idx;
    logic        out_full;
    logic        out_empty;
    logic        in_complete;
    logic [3:0]  in_complete_idx;
    logic [31:0] in_complete_data;
    logic [2:0]  in_complete_exception_vector;
    logic [31:0] in_complete_addr_miss;
    logic        in_flush;
    logic        out_commit_write_enable;
    logic [4:0]  out_commit_reg;
    logic [31:0] out_commit_data;
    logic        out_commit_store;
    logic [3:0]  out_commit_idx;
    logic        out_exception;
    logic [2:0]  out_exception_vector;
    logic [31:0] out_exception_pc;
    logic [31:0] out_addr_miss;

    always #5 clk = ~clk;

    reorder_buffer dut (
        .clk                          (clk),
        .reset                        (reset),
        .in_allocate                  (in_allocate),
        .in_allocate_rd               (in_allocate_rd),
        .in_allocate_wb               (in_allocate_wb),
        .in_allocate_is_store         (in_allocate_is_store),
        .in_allocate_pc               (in_allocate_pc),
        .out_allocate_idx             (out_allocate_idx),
        .out_full                     (out_full),
        .out_empty                    (out_empty),
        .in_complete                  (in_complete),
        .in_complete_idx              (in_complete_idx),
        .in_complete_data             (in_complete_data),
        .in_complete_exception_vector (in_complete_exception_vector),
        .in_complete_addr_miss        (in_complete_addr_miss),
        .in_flush                     (in_flush),
        .out_commit_write_enable      (out_commit_write_enable),
        .out_commit_reg               (out_commit_reg),
        .out_commit_data              (out_commit_data),
        .out_commit_store             (out_commit_store),
        .out_commit_idx               (out_commit_idx),
        .out_exception                (out_exception),
        .out_exception_vector         (out_exception_vector),
        .out_exception_pc             (out_exception_pc),
        .out_addr_miss                (out_addr_miss)
    );

    // Program-order model: the queue front is the oldest live instruction.
    typedef struct {
        int          idx;
        logic [4:0]  rd;
        bit          wb;
        bit          st;
        logic [31:0] pc;
        bit          done;
        logic [31:0] data;
        logic [2:0]  exc;
        logic [31:0] addr;
    } rec_t;

    rec_t mq[$];
    int   m_tail;
    int   n_cmp;
    int   n_err;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h, expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check_val({tag, "_we"},    32'(out_commit_write_enable), 32'd0);
        check_val({tag, "_store"}, 32'(out_commit_store),        32'd0);
        check_val({tag, "_exc"},   32'(out_exception),           32'd0);
        check_val({tag, "_idx"},   32'(out_commit_idx),          32'd0);
        check_val({tag, "_empty"}, 32'(out_empty),               32'd1);
        check_val({tag, "_full"},  32'(out_full),                32'd0);
        check_val({tag, "_aidx"},  32'(out_allocate_idx),        32'd0);
    endtask

    // One clock cycle: drive, check status, advance model, check retirement.
    task automatic step(input bit a = 0, input logic [4:0] rd = 0, input bit wb = 0,
                        input bit st = 0, input logic [31:0] pc = 0,
                        input bit c = 0, input logic [3:0] ci = 0,
                        input logic [31:0] cd = 0, input logic [2:0] ce = 0,
                        input logic [31:0] ca = 0, input bit fl = 0);
        bit          e_we, e_st, e_exc;
        logic [4:0]  e_reg;
        logic [31:0] e_data, e_pc, e_addr;
        logic [2:0]  e_vec;
        int          e_idx;
        bit          full_now, retire;
        rec_t        h, r;

        in_allocate = a; in_allocate_rd = rd; in_allocate_wb = wb;
        in_allocate_is_store = st; in_allocate_pc = pc;
        in_complete = c; in_complete_idx = ci; in_complete_data = cd;
        in_complete_exception_vector = ce; in_complete_addr_miss = ca;
        in_flush = fl;
        #1;
        check_val("alloc_idx", 32'(out_allocate_idx), 32'(m_tail));
        check_val("full",      32'(out_full),  32'(mq.size() == N));
        check_val("empty",     32'(out_empty), 32'(mq.size() == 0));

        e_we = 0; e_st = 0; e_exc = 0; e_reg = 0; e_data = 0;
        e_pc = 0; e_addr = 0; e_vec = 0; e_idx = 0;
        full_now = (mq.size() == N);
        retire   = (mq.size() > 0) && mq[0].done;
        if (retire) h = mq[0];

        if (retire && h.exc != 0) begin
            e_exc = 1; e_vec = h.exc; e_pc = h.pc; e_addr = h.addr; e_idx = h.idx;
            mq.delete(); m_tail = 0;
        end else if (fl) begin
            mq.delete(); m_tail = 0;
        end else begin
            if (c) begin
                foreach (mq[i]) begin
                    if (mq[i].idx == int'(ci)) begin
                        mq[i].done = 1; mq[i].data = cd; mq[i].exc = ce; mq[i].addr = ca;
                    end
                end
            end
            if (retire) begin
                e_idx = h.idx;
                if (h.wb && h.rd != 0) begin
                    e_we = 1; e_reg = h.rd; e_data = h.data;
                end
                e_st = h.st;
                void'(mq.pop_front());
            end
            if (a && !full_now) begin
                r = '{idx: m_tail, rd: rd, wb: wb, st: st, pc: pc, done: 0,
                      data: 0, exc: 0, addr: 0};
                mq.push_back(r);
                m_tail = (m_tail + 1) % N;
            end
        end

        @(posedge clk);
        #1;
        check_val("commit_we",   32'(out_commit_write_enable), 32'(e_we));
        check_val("commit_reg",  32'(out_commit_reg),          32'(e_reg));
        check_val("commit_data", out_commit_data,              e_data);
        check_val("commit_st",   32'(out_commit_store),        32'(e_st));
        check_val("commit_idx",  32'(out_commit_idx),          32'(e_idx));
        check_val("exc",         32'(out_exception),           32'(e_exc));
        check_val("exc_vec",     32'(out_exception_vector),    32'(e_vec));
        check_val("exc_pc",      out_exception_pc,             e_pc);
        check_val("exc_addr",    out_addr_miss,                e_addr);
    endtask

    task automatic random_step();
        bit          a, wb, st, c, fl;
        logic [4:0]  rd;
        logic [3:0]  ci;
        logic [2:0]  ce;
        a  = ($urandom_range(0, 9) < 7);
        rd = 5'($urandom_range(0, 31));
        st = ($urandom_range(0, 3) == 0);
        wb = st ? 1'b0 : 1'($urandom_range(0, 1));
        c  = ($urandom_range(0, 9) < 6);
        if (mq.size() > 0 && $urandom_range(0, 7) != 0)
            ci = 4'(mq[$urandom_range(0, mq.size() - 1)].idx);
        else
            ci = 4'($urandom_range(0, 15));
        ce = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
        fl = ($urandom_range(0, 24) == 0);
        step(a, rd, wb, st, $urandom, c, ci, $urandom, ce, $urandom, fl);
    endtask

    initial begin
        n_cmp = 0; n_err = 0; m_tail = 0;
        reset = 1'b1;
        in_allocate = 0; in_allocate_rd = 0; in_allocate_wb = 0;
        in_allocate_is_store = 0; in_allocate_pc = 0;
        in_complete = 0; in_complete_idx = 0; in_complete_data = 0;
        in_complete_exception_vector = 0; in_complete_addr_miss = 0;
        in_flush = 0;
        #2;
        check_idle_outputs("reset");
        @(posedge clk); #1;
        reset = 1'b0;

        // Out-of-order completion, in-order retirement of x5, x6, x7.
        step(.a(1), .rd(5), .wb(1), .pc(32'h100));
        step(.a(1), .rd(6), .wb(1), .pc(32'h104));
        step(.a(1), .rd(7), .wb(1), .pc(32'h108));
        step(.c(1), .ci(2), .cd(32'hC0DE_0007));
        step(.c(1), .ci(1), .cd(32'hC0DE_0006));
        step(.c(1), .ci(0), .cd(32'hC0DE_0005));
        repeat (4) step();

        // Fill from index 0, refused 11th allocate, then drain one.
        step(.fl(1));
        for (int i = 0; i < N; i++) step(.a(1), .rd(5'(i + 1)), .wb(1), .pc(32'h200 + 32'(i)));
        step(.a(1), .rd(31), .wb(1), .pc(32'hDEAD));
        step(.c(1), .ci(0), .cd(32'h1234_5678));
        step(.a(1), .rd(9), .wb(1), .pc(32'h300));
        step();

        // Exception at the head wipes younger entries.
        step(.fl(1));
        step(.a(1), .rd(1), .wb(1), .pc(32'h400));
        step(.a(1), .rd(2), .wb(1), .pc(32'h404));
        step(.a(1), .rd(3), .wb(1), .pc(32'h408));
        step(.c(1), .ci(1), .cd(32'h11));
        step(.c(1), .ci(0), .cd(32'h22), .ce(3'd2), .ca(32'h1000));
        step();
        step();

        // Store at the head, then rd = 0 with wb.
        step(.a(1), .st(1), .pc(32'h500));
        step(.a(1), .rd(0), .wb(1), .pc(32'h504));
        step(.c(1), .ci(0), .cd(32'h55));
        step(.c(1), .ci(1), .cd(32'h66));
        repeat (2) step();

        // Flush together with allocate and complete.
        step(.a(1), .rd(4), .wb(1), .pc(32'h600));
        step(.a(1), .rd(5), .wb(1), .c(1), .ci(2), .cd(32'h77), .fl(1));
        step();

        for (int k = 0; k < 300; k++) begin
            random_step();
            if (k == 150) begin
                reset = 1'b1;
                #1;
                check_idle_outputs("midreset");
                @(posedge clk); #1;
                reset = 1'b0;
                mq.delete();
                m_tail = 0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_reorder_buffer
`default_nettype wire
